// File: rtl/transpose_stream_buffer_if.sv
// Row-stream bundle for the transpose buffer: input rows in, transposed/bypassed rows out.
// No storage or latency of its own; valid/ready on each side.
// The slave modport is the buffer's view; the master modport is the producer/consumer view.
interface transpose_stream_buffer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8
);
    localparam int ROW_W = NUM_PE * DATA_WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [ROW_W-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic             out_last;
    logic             out_mode;

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_last, out_mode
    );

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_mode
    );
endinterface

// File: rtl/transpose_stream_buffer.sv
// Ping-pong NUM_PE x NUM_PE block transpose/bypass buffer; one row per cycle sustained.
// Latency: first row out 1 cycle after a block's last row is accepted (2 with TSB_OUT_REG_EN skid output).
// Backpressure: in_ready drops while both banks hold blocks; out_* hold steady while out_ready is low.
module transpose_stream_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int NUM_PE     = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    transpose_stream_buffer_if.slave bus,
    output logic                    busy
);
    localparam int ROW_W = NUM_PE * DATA_WIDTH;
    localparam int CW    = $clog2(NUM_PE);
    localparam logic [CW-1:0] LAST_ROW = CW'(NUM_PE - 1);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_t;

    bank_st_t         st_q [2];
    bank_st_t         st_d [2];
    logic             mode_q [2];
    logic [ROW_W-1:0] mem [2][NUM_PE];

    logic          wr_sel_q, wr_sel_d, rd_sel_q, rd_sel_d;
    logic [CW-1:0] wr_row_q, wr_row_d, rd_row_q, rd_row_d;

    logic             acc;
    logic             rd_vld, rd_rdy, rd_fire;
    logic [ROW_W-1:0] rd_dat;
    logic             rd_last, rd_mode;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]  <= EMPTY;
            st_q[1]  <= EMPTY;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_row_q <= '0;
            rd_row_q <= '0;
        end else begin
            st_q[0]  <= st_d[0];
            st_q[1]  <= st_d[1];
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_row_q <= wr_row_d;
            rd_row_q <= rd_row_d;
        end
    end

    // Row storage and mode latch are deliberately left unreset
    always_ff @(posedge clk) begin
        if (acc) begin
            mem[wr_sel_q][wr_row_q] <= bus.in_data;
            if (wr_row_q == '0)
                mode_q[wr_sel_q] <= bus.in_mode;
        end
    end

    // Next state: write and read never target the same bank, so both may apply in one cycle
    always_comb begin
        st_d[0]  = st_q[0];
        st_d[1]  = st_q[1];
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_row_d = wr_row_q;
        rd_row_d = rd_row_q;
        if (acc) begin
            if (wr_row_q == LAST_ROW) begin
                st_d[wr_sel_q] = FULL;
                wr_row_d       = '0;
                wr_sel_d       = !wr_sel_q;
            end else begin
                st_d[wr_sel_q] = FILLING;
                wr_row_d       = wr_row_q + 1'b1;
            end
        end
        if (rd_fire) begin
            if (rd_row_q == LAST_ROW) begin
                st_d[rd_sel_q] = EMPTY;
                rd_row_d       = '0;
                rd_sel_d       = !rd_sel_q;
            end else begin
                st_d[rd_sel_q] = DRAINING;
                rd_row_d       = rd_row_q + 1'b1;
            end
        end
    end

    // Outputs from registered state
    always_comb begin
        bus.in_ready = !rst && (st_q[wr_sel_q] == EMPTY || st_q[wr_sel_q] == FILLING);
        rd_vld       = (st_q[rd_sel_q] == FULL) || (st_q[rd_sel_q] == DRAINING);
        rd_dat       = '0;
        if (rd_vld) begin
            if (mode_q[rd_sel_q]) begin
                for (int c = 0; c < NUM_PE; c++)
                    rd_dat[c*DATA_WIDTH +: DATA_WIDTH] =
                        mem[rd_sel_q][CW'(c)][int'(rd_row_q)*DATA_WIDTH +: DATA_WIDTH];
            end else begin
                rd_dat = mem[rd_sel_q][rd_row_q];
            end
        end
        rd_last = rd_vld && (rd_row_q == LAST_ROW);
        rd_mode = rd_vld && mode_q[rd_sel_q];
    end

    assign acc     = bus.in_valid & bus.in_ready;
    assign rd_fire = rd_vld & rd_rdy;

`ifdef TSB_OUT_REG_EN
    logic             ov_q, ol_q, om_q, sv_q, sl_q, sm_q;
    logic [ROW_W-1:0] od_q, sd_q;

    // Skid slot catches the row in flight when the consumer stalls; rd_rdy is purely registered
    assign rd_rdy = !sv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ov_q <= 1'b0; od_q <= '0; ol_q <= 1'b0; om_q <= 1'b0;
            sv_q <= 1'b0; sd_q <= '0; sl_q <= 1'b0; sm_q <= 1'b0;
        end else if (!ov_q || bus.out_ready) begin
            if (sv_q) begin
                ov_q <= 1'b1; od_q <= sd_q; ol_q <= sl_q; om_q <= sm_q;
                sv_q <= 1'b0;
            end else begin
                ov_q <= rd_fire; od_q <= rd_dat; ol_q <= rd_last; om_q <= rd_mode;
            end
        end else if (rd_fire) begin
            sv_q <= 1'b1; sd_q <= rd_dat; sl_q <= rd_last; sm_q <= rd_mode;
        end
    end

    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_last  = ol_q;
    assign bus.out_mode  = om_q;
    assign busy          = (st_q[0] != EMPTY) || (st_q[1] != EMPTY) || ov_q || sv_q;
`else
    assign rd_rdy        = bus.out_ready;
    assign bus.out_valid = rd_vld;
    assign bus.out_data  = rd_dat;
    assign bus.out_last  = rd_last;
    assign bus.out_mode  = rd_mode;
    assign busy          = (st_q[0] != EMPTY) || (st_q[1] != EMPTY);
`endif
endmodule

// File: tb/tb_transpose_stream_buffer.sv
// Bench for transpose_stream_buffer: directed table checks, multi-cycle corner sequences,
// and random traffic against a block-level matrix reference model.
module tb_transpose_stream_buffer;
    localparam int DW = 16;
    localparam int NP = 4;
    localparam int RW = NP * DW;

    logic clk, rst, busy;

    transpose_stream_buffer_if #(.DATA_WIDTH(DW), .NUM_PE(NP)) bus ();
    transpose_stream_buffer #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    typedef struct {
        logic [RW-1:0] dat;
        logic          last;
        logic          mode;
    } exp_row_t;

    typedef struct {
        int          idx;
        int          col;
        logic [DW-1:0] elem;
        logic        last;
        logic        mode;
    } vec_t;

    exp_row_t      exp_q[$];
    logic [RW-1:0] cap_data[$];
    logic          cap_last[$];
    logic          cap_mode[$];
    int            cap_cyc[$];

    logic [RW-1:0] blk_rows[NP];
    int            blk_n = 0;
    logic          blk_mode = 1'b0;
    int            last_acc_cyc = 0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, want, cyc);
        end
    endtask

    // Reference: view a block as an element matrix m[row][col]; transpose emits m[c][r] at (r,c)
    task automatic push_block();
        logic [DW-1:0] m[NP][NP];
        exp_row_t e;
        for (int r = 0; r < NP; r++)
            for (int c = 0; c < NP; c++)
                m[r][c] = blk_rows[r][c*DW +: DW];
        for (int r = 0; r < NP; r++) begin
            e.dat = '0;
            for (int c = 0; c < NP; c++)
                e.dat[c*DW +: DW] = blk_mode ? m[c][r] : m[r][c];
            e.last = (r == NP - 1);
            e.mode = blk_mode;
            exp_q.push_back(e);
        end
    endtask

    // Monitor / scoreboard, sampling on the falling edge
    logic          hold = 1'b0;
    logic [RW-1:0] h_dat;
    logic          h_last, h_mode;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_q.delete();
            blk_n = 0;
            hold  = 1'b0;
        end else begin
            if (hold) begin
                chk("hold_data", bus.out_data, h_dat);
                chk("hold_last", bus.out_last, h_last);
                chk("hold_mode", bus.out_mode, h_mode);
            end
            if (!bus.out_valid) begin
                chk("idle_data", bus.out_data, '0);
                chk("idle_last", bus.out_last, 1'b0);
            end
            if (bus.out_valid && bus.out_ready) begin
                cap_data.push_back(bus.out_data);
                cap_last.push_back(bus.out_last);
                cap_mode.push_back(bus.out_mode);
                cap_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_row: got %h expected no row (cycle %0d)", bus.out_data, cyc);
                end else begin
                    exp_row_t e;
                    e = exp_q.pop_front();
                    chk("row_data", bus.out_data, e.dat);
                    chk("row_last", bus.out_last, e.last);
                    chk("row_mode", bus.out_mode, e.mode);
                end
            end
            hold   = bus.out_valid && !bus.out_ready;
            h_dat  = bus.out_data;
            h_last = bus.out_last;
            h_mode = bus.out_mode;
            if (bus.in_valid && bus.in_ready) begin
                blk_rows[blk_n] = bus.in_data;
                if (blk_n == 0) blk_mode = bus.in_mode;
                blk_n++;
                if (blk_n == NP) begin
                    push_block();
                    blk_n = 0;
                    last_acc_cyc = cyc;
                end
            end
        end
    end

    function automatic logic [RW-1:0] mk_row(input logic [3:0] tag, input int r);
        logic [RW-1:0] row;
        for (int c = 0; c < NP; c++)
            row[c*DW +: DW] = {4'h0, tag, 4'(r), 4'(c)};
        return row;
    endfunction

    task automatic send_rows(input logic [3:0] tag, input logic mode, input int tog_row,
                             input int first, input int last_r, output int stalls);
        stalls = 0;
        for (int r = first; r <= last_r; r++) begin
            int w;
            bus.in_valid = 1'b1;
            bus.in_data  = mk_row(tag, r);
            bus.in_mode  = (r >= tog_row) ? !mode : mode;
            w = 0;
            @(negedge clk);
            while (!bus.in_ready && w < 50) begin
                stalls++;
                w++;
                @(negedge clk);
            end
            if (!bus.in_ready) begin
                n_cmp++;
                n_err++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 (tag %0d row %0d)", tag, r);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        @(negedge clk);
        while ((busy || exp_q.size() != 0) && w < 300) begin
            w++;
            @(negedge clk);
        end
        if (busy || exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy=%0d pending=%0d expected 0/0", busy, exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    vec_t tbl[12];

    initial begin
        int s, s1, s2, s3, base, acc_rows;
        logic [RW-1:0] hd, tmp;

        tbl[0]  = '{0, 0, 16'h0000, 1'b0, 1'b1};
        tbl[1]  = '{0, 1, 16'h0010, 1'b0, 1'b1};
        tbl[2]  = '{1, 0, 16'h0001, 1'b0, 1'b1};
        tbl[3]  = '{1, 3, 16'h0031, 1'b0, 1'b1};
        tbl[4]  = '{2, 1, 16'h0012, 1'b0, 1'b1};
        tbl[5]  = '{3, 2, 16'h0023, 1'b1, 1'b1};
        tbl[6]  = '{3, 3, 16'h0033, 1'b1, 1'b1};
        tbl[7]  = '{4, 1, 16'h0001, 1'b0, 1'b0};
        tbl[8]  = '{5, 0, 16'h0010, 1'b0, 1'b0};
        tbl[9]  = '{6, 3, 16'h0023, 1'b0, 1'b0};
        tbl[10] = '{7, 2, 16'h0032, 1'b1, 1'b0};
        tbl[11] = '{7, 0, 16'h0030, 1'b1, 1'b0};

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset held for three cycles
        repeat (3) begin
            @(negedge clk);
            chk("rst_in_ready", bus.in_ready, 1'b0);
            chk("rst_out_valid", bus.out_valid, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_out_data", bus.out_data, '0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_out_mode", bus.out_mode, 1'b0);
        @(posedge clk);
        #1;

        // Transpose block then bypass block (mode flipped mid-block), checked from the table
        bus.out_ready = 1'b1;
        base = cap_data.size();
        send_rows(4'h0, 1'b1, 99, 0, NP - 1, s);
        wait_idle();
        if (cap_cyc.size() > base) chk("first_row_latency", cap_cyc[base] - last_acc_cyc, 1);
        else chk("first_row_latency", 0, 1);
        send_rows(4'h0, 1'b0, 2, 0, NP - 1, s);
        wait_idle();
        for (int i = 0; i < 12; i++) begin
            if (cap_data.size() > base + tbl[i].idx) begin
                tmp = cap_data[base + tbl[i].idx];
                chk($sformatf("tbl%0d_elem", i), tmp[tbl[i].col*DW +: DW], tbl[i].elem);
                chk($sformatf("tbl%0d_last", i), cap_last[base + tbl[i].idx], tbl[i].last);
                chk($sformatf("tbl%0d_mode", i), cap_mode[base + tbl[i].idx], tbl[i].mode);
            end else begin
                chk($sformatf("tbl%0d_present", i), cap_data.size(), base + tbl[i].idx + 1);
            end
        end

        // Three back-to-back blocks, modes 1,0,1
        base = cap_data.size();
        send_rows(4'h1, 1'b1, 99, 0, NP - 1, s1);
        send_rows(4'h2, 1'b0, 99, 0, NP - 1, s2);
        send_rows(4'h3, 1'b1, 99, 0, NP - 1, s3);
        chk("stream_stalls", s1 + s2 + s3, 0);
        wait_idle();
        chk("stream_rows", cap_data.size() - base, 3 * NP);
        if (cap_cyc.size() >= base + 3 * NP) begin
            chk("stream_contig", cap_cyc[base + 3*NP - 1] - cap_cyc[base], 3 * NP - 1);
            chk("stream_mode0", cap_mode[base], 1'b1);
            chk("stream_mode1", cap_mode[base + NP], 1'b0);
            chk("stream_mode2", cap_mode[base + 2*NP], 1'b1);
        end

        // Back-pressure: both banks full, ninth row must wait for a bank to empty
        bus.out_ready = 1'b0;
        send_rows(4'h4, 1'b1, 99, 0, NP - 1, s1);
        send_rows(4'h5, 1'b0, 99, 0, NP - 1, s2);
        chk("bp_fill_stalls", s1 + s2, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = mk_row(4'h6, 0);
        bus.in_mode  = 1'b1;
        @(negedge clk);
        hd = bus.out_data;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", bus.in_ready, 1'b0);
            chk("bp_data_stable", bus.out_data, hd);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        s = 0;
        @(negedge clk);
        while (!(bus.out_valid && bus.out_last) && s < 20) begin
            s++;
            @(negedge clk);
        end
        chk("bp_last_seen", bus.out_valid && bus.out_last, 1'b1);
        chk("bp_ready_at_last", bus.in_ready, 1'b0);
        @(negedge clk);
        chk("bp_ready_back", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        send_rows(4'h6, 1'b1, 99, 1, NP - 1, s);
        wait_idle();

        // Reset while block 1 drains and block 2 is half written
        send_rows(4'h7, 1'b1, 99, 0, NP - 1, s);
        send_rows(4'h8, 1'b0, 99, 0, 1, s);
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", bus.in_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        base = cap_data.size();
        @(negedge clk);
        chk("midrst_no_stale", bus.out_valid, 1'b0);
        @(posedge clk);
        #1;
        send_rows(4'h9, 1'b1, 99, 0, NP - 1, s);
        wait_idle();
        chk("midrst_rows", cap_data.size() - base, NP);

        // Random traffic against the reference model
        acc_rows = 0;
        for (int i = 0; i < 4000 && acc_rows < 40 * NP; i++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = {$urandom, $urandom};
            bus.in_mode   = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) acc_rows++;
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_idle();
        chk("rand_rows_accepted", acc_rows, 40 * NP);
        chk("final_busy", busy, 1'b0);
        chk("final_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
